// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU controller, datapath and memory responder.
package cpu_pkg;

  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one write or one registered read per cycle.
module mem_array
  import cpu_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] q
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en && !we) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: turns controller strobe edges into wait-stated reads and
// writes on the unified store, with completion pulses and a protocol-error flag.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int AWIDTH      = AWIDTH_DEF,
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              rd,
  input  logic              wr,
  input  logic              data_e,
  input  logic [AWIDTH-1:0] pc_addr,
  input  logic [AWIDTH-1:0] ir_addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              data_valid,
  output logic              wr_ack,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              rd_q, wr_q;
  logic              req_rd, req_wr;
  op_t               op_lat, op_next;
  logic [AWIDTH-1:0] addr_lat, addr_next, addr_sel;
  logic [DWIDTH-1:0] wdata_lat, wdata_next;

  logic              mem_en, mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              dv_next, ack_next, err_next, busy_next;

  assign req_rd   = rd & ~rd_q;
  assign req_wr   = wr & ~wr_q;
  assign addr_sel = sel ? pc_addr : ir_addr;

  // The RAM is touched only on the edge that enters RESP, so the completion
  // pulse and the new rdata become visible in the same cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_next    = op_lat;
    addr_next  = addr_lat;
    wdata_next = wdata_lat;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_lat;
    mem_wdata  = wdata_lat;
    dv_next    = 1'b0;
    ack_next   = 1'b0;
    err_next   = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_rd && req_wr) begin
          err_next = 1'b1;
        end else if (req_wr && !data_e) begin
          err_next = 1'b1;
        end else if (req_rd || req_wr) begin
          op_next    = req_wr ? OP_WR : OP_RD;
          addr_next  = addr_sel;
          wdata_next = wdata;
          cnt_next   = '0;
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            mem_en     = 1'b1;
            mem_we     = req_wr;
            mem_addr   = addr_sel;
            mem_wdata  = wdata;
            dv_next    = req_rd;
            ack_next   = req_wr;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_next = RESP;
          mem_en     = 1'b1;
          mem_we     = (op_lat == OP_WR);
          dv_next    = (op_lat == OP_RD);
          ack_next   = (op_lat == OP_WR);
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // Control state: reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      data_valid <= 1'b0;
      wr_ack     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      rd_q       <= rd;
      wr_q       <= wr;
      data_valid <= dv_next;
      wr_ack     <= ack_next;
      busy       <= busy_next;
      err        <= err_next;
    end
  end

  // Latched request fields carry no reset; they are rewritten on every accept.
  always_ff @(posedge clk) begin
    op_lat    <= op_next;
    addr_lat  <= addr_next;
    wdata_lat <= wdata_next;
  end

  mem_array #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en & ~rst),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .q     (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Drives three responders (1, 0 and 3 wait states) from one bus and checks each
// against a transaction-level model of the store.
module tb_mem_responder;

  logic       clk;
  logic       rst;
  logic       sel, rd, wr, data_e;
  logic [4:0] pc_addr, ir_addr;
  logic [7:0] wdata;

  logic [7:0] rdata_o [3];
  logic       dv_o    [3];
  logic       ack_o   [3];
  logic       busy_o  [3];
  logic       err_o   [3];

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .sel(sel), .rd(rd), .wr(wr), .data_e(data_e),
    .pc_addr(pc_addr), .ir_addr(ir_addr), .wdata(wdata),
    .rdata(rdata_o[0]), .data_valid(dv_o[0]), .wr_ack(ack_o[0]),
    .busy(busy_o[0]), .err(err_o[0])
  );

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .sel(sel), .rd(rd), .wr(wr), .data_e(data_e),
    .pc_addr(pc_addr), .ir_addr(ir_addr), .wdata(wdata),
    .rdata(rdata_o[1]), .data_valid(dv_o[1]), .wr_ack(ack_o[1]),
    .busy(busy_o[1]), .err(err_o[1])
  );

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .sel(sel), .rd(rd), .wr(wr), .data_e(data_e),
    .pc_addr(pc_addr), .ir_addr(ir_addr), .wdata(wdata),
    .rdata(rdata_o[2]), .data_valid(dv_o[2]), .wr_ack(ack_o[2]),
    .busy(busy_o[2]), .err(err_o[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: each accepted request is one atomic transaction that
  // completes W edges after acceptance; the bus is free again two edges later.
  logic [7:0] mmem [3][32];
  bit         pend [3];
  int         pend_edge [3];
  bit         pend_wr [3];
  logic [4:0] pend_addr [3];
  logic [7:0] pend_data [3];
  int         accept_from [3];
  int         busy_until [3];
  bit         prev_rd, prev_wr;
  logic [7:0] e_rdata [3];
  bit         e_dv [3], e_ack [3], e_err [3], e_busy [3];

  bit         s_rst, s_sel, s_rd, s_wr, s_de;
  logic [4:0] s_pc, s_ir;
  logic [7:0] s_wdata;

  function automatic int wait_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit rise_rd, rise_wr;
    rise_rd = s_rd && !prev_rd;
    rise_wr = s_wr && !prev_wr;
    for (int k = 0; k < 3; k++) begin
      e_dv[k]  = 1'b0;
      e_ack[k] = 1'b0;
      e_err[k] = 1'b0;
      if (s_rst) begin
        pend[k]        = 1'b0;
        accept_from[k] = 0;
        busy_until[k]  = -1;
        e_rdata[k]     = 8'h00;
        e_busy[k]      = 1'b0;
      end else begin
        if (cyc >= accept_from[k]) begin
          if ((rise_rd && rise_wr) || (rise_wr && !s_de)) begin
            e_err[k] = 1'b1;
          end else if (rise_rd || rise_wr) begin
            pend[k]        = 1'b1;
            pend_edge[k]   = cyc + wait_of(k);
            pend_wr[k]     = rise_wr;
            pend_addr[k]   = s_sel ? s_pc : s_ir;
            pend_data[k]   = s_wdata;
            busy_until[k]  = cyc + wait_of(k);
            accept_from[k] = cyc + wait_of(k) + 2;
          end
        end
        if (pend[k] && pend_edge[k] == cyc) begin
          if (pend_wr[k]) begin
            mmem[k][pend_addr[k]] = pend_data[k];
            e_ack[k] = 1'b1;
          end else begin
            e_rdata[k] = mmem[k][pend_addr[k]];
            e_dv[k]    = 1'b1;
          end
          pend[k] = 1'b0;
        end
        e_busy[k] = (cyc <= busy_until[k]);
      end
    end
    prev_rd = s_rst ? 1'b0 : s_rd;
    prev_wr = s_rst ? 1'b0 : s_wr;
  endtask

  task automatic tick();
    s_rst = rst; s_sel = sel; s_rd = rd; s_wr = wr; s_de = data_e;
    s_pc = pc_addr; s_ir = ir_addr; s_wdata = wdata;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("c%0d dut%0d data_valid", cyc, k), 32'(dv_o[k]), 32'(e_dv[k]));
      chk($sformatf("c%0d dut%0d wr_ack", cyc, k), 32'(ack_o[k]), 32'(e_ack[k]));
      chk($sformatf("c%0d dut%0d err", cyc, k), 32'(err_o[k]), 32'(e_err[k]));
      chk($sformatf("c%0d dut%0d busy", cyc, k), 32'(busy_o[k]), 32'(e_busy[k]));
      chk($sformatf("c%0d dut%0d rdata", cyc, k), 32'(rdata_o[k]), 32'(e_rdata[k]));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    sel = 1'b0; ir_addr = a; wdata = d; data_e = 1'b1; wr = 1'b1;
    tick();
    wr = 1'b0; data_e = 1'b0;
    ticks(6);
  endtask

  task automatic bus_read(input logic [4:0] a);
    sel = 1'b0; ir_addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    ticks(6);
  endtask

  initial begin
    int n_dv, n_err;
    rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; data_e = 1'b0;
    pc_addr = '0; ir_addr = '0; wdata = '0;
    prev_rd = 1'b0; prev_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0; accept_from[k] = 0; busy_until[k] = -1; e_rdata[k] = 8'h00;
    end
    ticks(3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset dut%0d rdata", k), 32'(rdata_o[k]), 32'h0);
      chk($sformatf("reset dut%0d busy", k), 32'(busy_o[k]), 32'h0);
    end
    rst = 1'b0;
    ticks(2);

    // Fill the whole store so every later read has a defined expectation.
    for (int a = 0; a < 32; a++) bus_write(5'(a), 8'($urandom));
    bus_write(5'd3, 8'hA5);
    bus_write(5'd7, 8'h11);

    // Held read strobe: one transaction, pulse after the wait state.
    sel = 1'b1; pc_addr = 5'd3; rd = 1'b1;
    tick();
    chk("t1 busy first", 32'(busy_o[0]), 32'h1);
    chk("t1 dv early", 32'(dv_o[0]), 32'h0);
    chk("t1 w0 dv next cycle", 32'(dv_o[1]), 32'h1);
    tick();
    chk("t1 dv", 32'(dv_o[0]), 32'h1);
    chk("t1 rdata", 32'(rdata_o[0]), 32'hA5);
    chk("t1 busy second", 32'(busy_o[0]), 32'h1);
    tick();
    chk("t1 dv drop", 32'(dv_o[0]), 32'h0);
    chk("t1 busy drop", 32'(busy_o[0]), 32'h0);
    tick();
    rd = 1'b0;
    ticks(6);

    // IR-addressed write then read-back.
    sel = 1'b0; ir_addr = 5'h1E; wdata = 8'h3C; data_e = 1'b1; wr = 1'b1;
    tick();
    wr = 1'b0; data_e = 1'b0;
    tick();
    chk("t2 wr_ack", 32'(ack_o[0]), 32'h1);
    ticks(5);
    bus_read(5'h1E);
    chk("t2 readback", 32'(rdata_o[0]), 32'h3C);

    // Protocol misuse.
    sel = 1'b0; ir_addr = 5'h1E; wdata = 8'h77; data_e = 1'b0; wr = 1'b1;
    tick();
    chk("t3 err no data_e", 32'(err_o[0]), 32'h1);
    chk("t3 busy", 32'(busy_o[0]), 32'h0);
    wr = 1'b0;
    ticks(4);
    rd = 1'b1; wr = 1'b1; data_e = 1'b1;
    tick();
    chk("t3 err rd+wr", 32'(err_o[2]), 32'h1);
    rd = 1'b0; wr = 1'b0; data_e = 1'b0;
    ticks(6);
    bus_read(5'h1E);
    chk("t3 mem unchanged", 32'(rdata_o[0]), 32'h3C);

    // Strobe edges during WAIT are dropped.
    n_dv = 0; n_err = 0;
    sel = 1'b0; ir_addr = 5'd3; rd = 1'b1;
    tick(); n_dv += dv_o[2]; n_err += err_o[2];
    rd = 1'b0;
    tick(); n_dv += dv_o[2]; n_err += err_o[2];
    rd = 1'b1; wr = 1'b1; data_e = 1'b0;
    tick(); n_dv += dv_o[2]; n_err += err_o[2];
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); n_dv += dv_o[2]; n_err += err_o[2];
    end
    chk("t4 single dv", 32'(n_dv), 32'd1);
    chk("t4 no err", 32'(n_err), 32'd0);
    chk("t4 rdata", 32'(rdata_o[2]), 32'hA5);

    // Reset during the wait state of a write.
    sel = 1'b0; ir_addr = 5'd7; wdata = 8'h99; data_e = 1'b1; wr = 1'b1;
    tick();
    wr = 1'b0; data_e = 1'b0; rst = 1'b1;
    tick();
    chk("t5 rdata", 32'(rdata_o[0]), 32'h0);
    chk("t5 ack", 32'(ack_o[0]), 32'h0);
    chk("t5 busy", 32'(busy_o[0]), 32'h0);
    chk("t5 dv", 32'(dv_o[0]), 32'h0);
    rst = 1'b0;
    ticks(2);
    bus_read(5'd7);
    chk("t5 mem kept", 32'(rdata_o[0]), 32'h11);
    chk("t5 w3 mem kept", 32'(rdata_o[2]), 32'h11);

    // Random traffic, including collisions, misuse and occasional reset.
    for (int i = 0; i < 600; i++) begin
      rd      = ($urandom_range(0, 3) == 0);
      wr      = ($urandom_range(0, 4) == 0);
      data_e  = ($urandom_range(0, 5) != 0);
      sel     = 1'($urandom);
      pc_addr = 5'($urandom);
      ir_addr = 5'($urandom);
      wdata   = 8'($urandom);
      rst     = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    ticks(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
